dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage data port (address, write data, MemRead, MemWrite, funct3 in; read data out).
- Holds a word-organised data RAM and serves each access after a configurable number of wait states.
- Asserts a stall back to the pipeline until the response is ready.
- Performs RV32I byte/half/word sizing, load sign/zero extension and store byte-lane merging.

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_lane_unit.sv | 53 +++++
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MEM-stage data RAM responder.
package dmem_responder_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane logic: store merge, load extract/extend and access legality.
module dmem_lane_unit
    import dmem_responder_pkg::*;
(
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic            is_write,
    output logic [XLEN-1:0] new_word,
    output logic [XLEN-1:0] load_word,
    output logic            err
);

    logic [XLEN-1:0] shifted;

    assign shifted = old_word >> {lane, 3'b000};

    always_comb begin
        err = 1'b0;
        unique case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = lane[0];
            F3_W:    err = (lane != 2'b00);
            F3_BU:   err = is_write;
            F3_HU:   err = is_write | lane[0];
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        new_word = old_word;
        unique case (funct3)
            F3_B:    new_word[{lane, 3'b000} +: 8] = data[7:0];
            F3_H:    new_word[{lane[1], 4'b0000} +: 16] = data[15:0];
            F3_W:    new_word = data;
            default: new_word = old_word;
        endcase
    end

    always_comb begin
        load_word = '0;
        unique case (funct3)
            F3_B:    load_word = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_word = {24'h0, shifted[7:0]};
            F3_H:    load_word = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_word = {16'h0, shifted[15:0]};
            F3_W:    load_word = old_word;
            default: load_word = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data RAM responder for the MEM stage: wait-state FSM, stall, sized access.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] write_data,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] read_data,
    output logic            mem_stall,
    output logic            mem_done,
    output logic            access_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    state_t state, state_nx;
    logic [3:0] cnt;
    logic [XLEN-1:0] lat_addr, lat_data;
    logic [2:0] lat_f3;
    logic lat_rd, lat_wr;
    logic [XLEN-1:0] ram [DEPTH_WORDS];

    logic req, in_idle, commit, err;
    logic cur_rd, cur_wr;
    logic [2:0] cur_f3;
    logic [XLEN-1:0] cur_addr, cur_data;
    logic [XLEN-1:0] old_word, new_word, load_word;
    logic [ADDR_W-1:0] idx;
    logic unused;

    assign req     = mem_read | mem_write;
    assign in_idle = (state == IDLE);

    // With zero wait states the access completes straight out of IDLE,
    // so the live inputs stand in for the latched copy.
    assign cur_addr = in_idle ? addr : lat_addr;
    assign cur_data = in_idle ? write_data : lat_data;
    assign cur_f3   = in_idle ? funct3 : lat_f3;
    assign cur_rd   = in_idle ? mem_read : lat_rd;
    assign cur_wr   = in_idle ? mem_write : lat_wr;

    assign idx      = cur_addr[ADDR_W+1:2];
    assign old_word = ram[idx];
    assign commit   = rst_n && (state_nx == RESP);
    assign unused   = ^cur_addr[XLEN-1:ADDR_W+2];

    dmem_lane_unit u_lane (
        .old_word  (old_word),
        .data      (cur_data),
        .funct3    (cur_f3),
        .lane      (cur_addr[1:0]),
        .is_write  (cur_wr),
        .new_word  (new_word),
        .load_word (load_word),
        .err       (err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mem_stall = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    state_nx  = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (cnt <= 4'd1) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_f3     <= '0;
            lat_rd     <= 1'b0;
            lat_wr     <= 1'b0;
            read_data  <= '0;
            mem_done   <= 1'b0;
            access_err <= 1'b0;
        end else begin
            if (in_idle && req) begin
                cnt      <= WAIT_N;
                lat_addr <= addr;
                lat_data <= write_data;
                lat_f3   <= funct3;
                lat_rd   <= mem_read;
                lat_wr   <= mem_write;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            mem_done   <= commit;
            access_err <= commit & err;
            // Plain stores keep the last load result; a read+write combo
            // is a store that reports no load data.
            if (commit) begin
                if (err)         read_data <= '0;
                else if (!cur_wr) read_data <= load_word;
                else if (cur_rd)  read_data <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && cur_wr && !err) ram[idx] <= new_word;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder with 2 and 0 wait states.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst2_n, rd2, wr2;
    logic [31:0] a2, d2, q2;
    logic [2:0]  f2;
    logic        st2, dn2, er2;

    logic        rst0_n, rd0, wr0;
    logic [31:0] a0, d0, q0;
    logic [2:0]  f0;
    logic        st0, dn0, er0;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst2_n), .mem_read(rd2), .mem_write(wr2),
        .addr(a2), .write_data(d2), .funct3(f2), .read_data(q2),
        .mem_stall(st2), .mem_done(dn2), .access_err(er2)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst0_n), .mem_read(rd0), .mem_write(wr0),
        .addr(a0), .write_data(d0), .funct3(f0), .read_data(q0),
        .mem_stall(st0), .mem_done(dn0), .access_err(er0)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f3;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t v[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w2, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3);
        if (w2) begin
            rd2 = rd; wr2 = wr; a2 = a; d2 = d; f2 = f3;
        end else begin
            rd0 = rd; wr0 = wr; a0 = a; d0 = d; f0 = f3;
        end
    endtask

    // One access: inputs held for the accept cycle only, then scrambled.
    task automatic acc(input bit w2, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, output int stalls,
                       output int done_at, output logic [31:0] q,
                       output logic e);
        logic st, dn;
        @(posedge clk); #1;
        drive(w2, rd, wr, a, d, f3);
        stalls = 0;
        done_at = -1;
        q = '0;
        e = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            st = w2 ? st2 : st0;
            dn = w2 ? dn2 : dn0;
            if (st) stalls++;
            if (dn) begin
                done_at = c;
                q = w2 ? q2 : q0;
                e = w2 ? er2 : er0;
                break;
            end
            @(posedge clk); #1;
            drive(w2, 1'b0, 1'b0, ~a, ~d, 3'b111);
        end
    endtask

    int          s, t;
    logic [31:0] q;
    logic        e;

    initial begin
        rst2_n = 1'b0; rst0_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
        #12;
        chk("rst_rdata", q2, 32'h0);
        chk("rst_stall", 32'(st2), 32'h0);
        chk("rst_done", 32'(dn2), 32'h0);
        chk("rst_err", 32'(er2), 32'h0);
        chk("rst0_outs", {q0[28:0], st0, dn0, er0}, 32'h0);
        @(posedge clk); #1;
        rst2_n = 1'b1; rst0_n = 1'b1;

        // preload, then abandon a store with a reset in WAIT
        acc(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, s, t, q, e);
        chk("preload_done", 32'(t), 32'd3);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
        chk("wait_stall", 32'(st2), 32'h1);
        #2 rst2_n = 1'b0;
        #1;
        chk("mrst_rdata", q2, 32'h0);
        chk("mrst_flags", {29'h0, st2, dn2, er2}, 32'h0);
        chk("mrst_state", 32'(u2.state), 32'h0);
        @(posedge clk); #1;
        rst2_n = 1'b1;
        acc(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, s, t, q, e);
        chk("mrst_lw", q, 32'h0);
        chk("mrst_lw_err", 32'(e), 32'h0);

        v.push_back('{1'b0, 1'b1, 32'h20,  32'h12345678, 3'b010, 32'h00000000, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h20,  32'h0,        3'b010, 32'h12345678, 1'b0});
        v.push_back('{1'b0, 1'b1, 32'h40,  32'h80FF7F01, 3'b010, 32'h12345678, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h43,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h43,  32'h0,        3'b100, 32'h00000080, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h42,  32'h0,        3'b001, 32'hFFFF80FF, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h40,  32'h0,        3'b101, 32'h00007F01, 1'b0});
        v.push_back('{1'b0, 1'b1, 32'h41,  32'h000000AA, 3'b000, 32'h00007F01, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h40,  32'h0,        3'b010, 32'h80FFAA01, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h22,  32'h0,        3'b010, 32'h00000000, 1'b1});
        v.push_back('{1'b1, 1'b0, 32'h40,  32'h0,        3'b010, 32'h80FFAA01, 1'b0});
        v.push_back('{1'b0, 1'b1, 32'h21,  32'h0000BEEF, 3'b001, 32'h00000000, 1'b1});
        v.push_back('{1'b1, 1'b0, 32'h20,  32'h0,        3'b010, 32'h12345678, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h20,  32'h0,        3'b011, 32'h00000000, 1'b1});
        v.push_back('{1'b0, 1'b1, 32'h20,  32'h000000FF, 3'b100, 32'h00000000, 1'b1});
        v.push_back('{1'b1, 1'b0, 32'h21,  32'h0,        3'b001, 32'h00000000, 1'b1});
        v.push_back('{1'b0, 1'b1, 32'h400, 32'h00000055, 3'b010, 32'h00000000, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h000, 32'h0,        3'b010, 32'h00000055, 1'b0});
        v.push_back('{1'b0, 1'b1, 32'h22,  32'h1234CAFE, 3'b001, 32'h00000055, 1'b0});
        v.push_back('{1'b1, 1'b0, 32'h20,  32'h0,        3'b010, 32'hCAFE5678, 1'b0});

        foreach (v[i]) begin
            acc(1'b1, v[i].rd, v[i].wr, v[i].a, v[i].d, v[i].f3, s, t, q, e);
            chk($sformatf("v%0d_rdata", i), q, v[i].exp);
            chk($sformatf("v%0d_err", i), 32'(e), 32'(v[i].err));
            chk($sformatf("v%0d_stalls", i), 32'(s), 32'd3);
            chk($sformatf("v%0d_done_at", i), 32'(t), 32'd3);
        end
        @(negedge clk);
        chk("done_strobe", 32'(dn2), 32'h0);

        // zero wait states
        acc(1'b0, 1'b0, 1'b1, 32'h8, 32'h11223344, 3'b010, s, t, q, e);
        chk("w0_sw_stalls", 32'(s), 32'd1);
        acc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 3'b010, s, t, q, e);
        chk("w0_lw_rdata", q, 32'h11223344);
        chk("w0_lw_stalls", 32'(s), 32'd1);
        chk("w0_lw_done_at", 32'(t), 32'd1);
        acc(1'b0, 1'b1, 1'b1, 32'hC, 32'h00000077, 3'b010, s, t, q, e);
        chk("w0_rw_rdata", q, 32'h0);
        chk("w0_rw_err", 32'(e), 32'h0);
        acc(1'b0, 1'b1, 1'b0, 32'hC, 32'h0, 3'b010, s, t, q, e);
        chk("w0_rw_stored", q, 32'h00000077);
        acc(1'b0, 1'b1, 1'b0, 32'hA, 32'h0, 3'b010, s, t, q, e);
        chk("w0_misalign_err", 32'(e), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
